// File: rtl/accum_pkg.sv
// Shared types and helpers for the ternary accumulator bank.
// Optional readback (ACCUM_BANK_READBACK_EN) is handled in accum_bank and accum_lane.
package accum_pkg;

    // Trit encoding on the step bus; 2'b10 is reserved and decodes to zero.
    typedef enum logic [1:0] {
        TRIT_ZERO = 2'b00,
        TRIT_POS  = 2'b01,
        TRIT_RSVD = 2'b10,
        TRIT_NEG  = 2'b11
    } trit_t;

    function automatic logic signed [1:0] trit_to_signed(input trit_t t);
        logic signed [1:0] v;
        case (t)
            TRIT_POS: v = 2'sb01;
            TRIT_NEG: v = 2'sb11;
            default:  v = 2'sb00;
        endcase
        return v;
    endfunction

    // Bit width able to index/count n values, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        if (n <= 32'd2) begin
            w = 32'd1;
        end else begin
            w = 32'($clog2(n));
        end
        return w;
    endfunction

endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: signed trit integrator with symmetric threshold triggers and leak.
// Exposes its count only when ACCUM_BANK_READBACK_EN is defined.
module accum_lane
    import accum_pkg::*;
#(
    parameter int unsigned COUNT_W   = 9,
    parameter int unsigned THRESHOLD = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               prop_i,
    input  logic               clear_i,
    input  logic               leak_tick_i,
    input  logic [1:0]         step_i,
    output logic               trig_pos_o,
    output logic               trig_neg_o,
    output logic               trig_nxt_c
`ifdef ACCUM_BANK_READBACK_EN
    ,
    output logic [COUNT_W-1:0] count_o
`endif
);

    localparam logic signed [COUNT_W-1:0] POS_LIM = COUNT_W'(THRESHOLD - 32'd1);
    localparam logic signed [COUNT_W-1:0] NEG_LIM = -POS_LIM;
    localparam logic signed [COUNT_W-1:0] ONE     = COUNT_W'(1);

    logic signed [COUNT_W-1:0] count_q, count_d;
    logic                      pos_q, pos_d;
    logic                      neg_q, neg_d;
    logic signed [1:0]         step_val;
    logic signed [COUNT_W-1:0] step_ext;
    logic signed [COUNT_W-1:0] sum;

    assign step_val = trit_to_signed(trit_t'(step_i));
    assign step_ext = COUNT_W'(step_val);
    assign sum      = count_q + step_ext;

    // A trigger pre-empts leak; otherwise leak pulls the new sum one step toward zero.
    always_comb begin
        count_d = count_q;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (prop_i) begin
            if (step_val == 2'sb01 && count_q == POS_LIM) begin
                pos_d   = 1'b1;
                count_d = '0;
            end else if (step_val == 2'sb11 && count_q == NEG_LIM) begin
                neg_d   = 1'b1;
                count_d = '0;
            end else if (leak_tick_i && sum != '0) begin
                count_d = sum[COUNT_W-1] ? (sum + ONE) : (sum - ONE);
            end else begin
                count_d = sum;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    assign trig_pos_o = pos_q;
    assign trig_neg_o = neg_q;
    assign trig_nxt_c = pos_d | neg_d;

`ifdef ACCUM_BANK_READBACK_EN
    assign count_o = count_q;
`endif

endmodule

// File: rtl/accum_bank.sv
// N_CH-lane leaky ternary accumulator bank with a shared leak timer and registered trig_any.
// Define ACCUM_BANK_READBACK_EN to add the rd_sel/rd_count per-lane count readback.
module accum_bank
    import accum_pkg::*;
#(
    parameter  int unsigned N_CH        = 8,
    parameter  int unsigned COUNT_W     = 9,
    parameter  int unsigned THRESHOLD   = 255,
    parameter  int unsigned LEAK_PERIOD = 16,
    localparam int unsigned SEL_W       = clog2_min1(N_CH)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                prop_in,
    input  logic                clear_in,
    input  logic [2*N_CH-1:0]   step_in,
    output logic [N_CH-1:0]     trig_pos,
    output logic [N_CH-1:0]     trig_neg,
    output logic                trig_any
`ifdef ACCUM_BANK_READBACK_EN
    ,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [COUNT_W-1:0]  rd_count
`endif
);

    localparam int unsigned TIMER_W  = clog2_min1(LEAK_PERIOD);
    localparam int unsigned LIM_MAX  = (32'd1 << (COUNT_W - 32'd1)) - 32'd1;

    if (THRESHOLD < 32'd1 || THRESHOLD > LIM_MAX || N_CH < 32'd1) begin : g_bad_cfg
        $error("accum_bank: need N_CH >= 1 and 1 <= THRESHOLD <= 2^(COUNT_W-1)-1");
    end

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               leak_tick;
    logic [N_CH-1:0]    trig_nxt;
    logic               any_q;

    assign leak_tick = (LEAK_PERIOD != 32'd0) &&
                       (timer_q == TIMER_W'(LEAK_PERIOD - 32'd1));

    // Leak timer advances only on propagate cycles and stays parked at 0 when leak is off.
    always_comb begin
        timer_d = timer_q;
        if (clear_in || LEAK_PERIOD == 32'd0) begin
            timer_d = '0;
        end else if (prop_in) begin
            timer_d = leak_tick ? '0 : (timer_q + TIMER_W'(1));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            timer_q <= '0;
            any_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            any_q   <= |trig_nxt;
        end
    end

    assign trig_any = any_q;

`ifdef ACCUM_BANK_READBACK_EN
    localparam int unsigned RD_DEPTH = 32'd1 << SEL_W;

    logic [COUNT_W-1:0] lane_count [RD_DEPTH];
    logic [COUNT_W-1:0] rd_count_q, rd_count_d;

    // Unpopulated select codes read back as zero.
    for (genvar j = N_CH; j < RD_DEPTH; j++) begin : g_rd_pad
        assign lane_count[j] = '0;
    end

    always_comb begin
        rd_count_d = lane_count[rd_sel];
        if (clear_in) begin
            rd_count_d = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        accum_lane #(
            .COUNT_W   (COUNT_W),
            .THRESHOLD (THRESHOLD)
        ) u_lane (
            .clk_i       (clk_in),
            .rst_i       (rst_in),
            .prop_i      (prop_in),
            .clear_i     (clear_in),
            .leak_tick_i (leak_tick),
            .step_i      (step_in[2*i +: 2]),
            .trig_pos_o  (trig_pos[i]),
            .trig_neg_o  (trig_neg[i]),
            .trig_nxt_c  (trig_nxt[i])
`ifdef ACCUM_BANK_READBACK_EN
            ,
            .count_o     (lane_count[i])
`endif
        );
    end

endmodule
